// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: write FIFO feeding a start/data/[parity]/stop serialiser.
// Define UART_TX_PARITY_EN to compile in the parity bit; the default build has no parity.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_50MHz,
    input  logic                          reset,
    input  logic                          sample_tick,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          stop2,
    input  logic                          parity_odd,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done_tick,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_overflow;

    state_t               r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_stop2;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_bit_end;

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign w_push    = wr_en && (!w_full || w_pop);
    assign w_bit_end = sample_tick && (r_tick == TW'(OVERSAMPLE - 1));

`ifdef UART_TX_PARITY_EN
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par_odd;
    logic                 w_parity;
    assign w_parity = (^r_data) ^ r_par_odd;
`else
    logic w_unused;
    assign w_unused = parity_odd;
`endif

    // NOTE: the storage array has no reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk_50MHz) begin
        if (w_push)
            r_mem[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
            if (wr_en && !w_push)
                r_overflow <= 1'b1;
        end
    end

    // NOTE: non-blocking reads of r_mem see the old head even when a full-FIFO push overwrites that slot.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_stop2 <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_data    <= '0;
            r_par_odd <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE && sample_tick)
                r_tick <= w_bit_end ? '0 : r_tick + TW'(1);
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_stop2 <= stop2;
`ifdef UART_TX_PARITY_EN
                        r_data    <= r_mem[r_rd_ptr];
                        r_par_odd <= parity_odd;
`endif
                        r_tick  <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift <= {1'b1, r_shift[DATA_BITS-1:1]};
                        if (r_bit == BW'(DATA_BITS - 1)) begin
                            r_bit <= '0;
`ifdef UART_TX_PARITY_EN
                            r_tx    <= w_parity;
                            r_state <= PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit <= r_bit + BW'(1);
                            r_tx  <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        if (r_stop2 && r_bit == '0) begin
                            r_bit <= BW'(1);
                        end else begin
                            r_bit   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx           = r_tx;
    assign tx_busy      = r_busy;
    assign tx_done_tick = r_done;
    assign fifo_full    = w_full;
    assign fifo_empty   = w_empty;
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DATA_BITS=8, OVERSAMPLE=16, FIFO_DEPTH=8).
// Expected frames follow UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_fifo;

    logic       clk_50MHz = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] data_in = '0;
    logic       stop2 = 1'b0;
    logic       parity_odd = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    uart_tx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(8)) dut (
        .clk_50MHz    (clk_50MHz),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .stop2        (stop2),
        .parity_odd   (parity_odd),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // One sample_tick every third clock, so tick-gated counting is actually exercised.
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk_50MHz);
            #1;
            phase = (phase == 2) ? 0 : phase + 1;
            sample_tick = (phase == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_len(input logic s2);
        return 1 + 8 + PAR_BITS + (s2 ? 2 : 1);
    endfunction

    // Line bits in time order: index 0 is the start bit, data LSB first, then parity, then stops.
    function automatic logic [15:0] exp_frame(input logic [7:0] d, input logic s2, input logic po);
        logic [15:0] f;
        logic [15:0] mask;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (PAR_BITS == 1)
            f[9] = (^d) ^ po;
        mask = (16'd1 << exp_len(s2)) - 16'd1;
        return f & mask;
    endfunction

    task automatic do_reset();
        @(negedge clk_50MHz);
        reset = 1'b1;
        wr_en = 1'b0;
        repeat (2) @(negedge clk_50MHz);
        reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        data_in = d;
        wr_en = 1'b1;
        @(negedge clk_50MHz);
        wr_en = 1'b0;
    endtask

    // Caller must be at a frame boundary; returns at the first negedge of START.
    task automatic wait_start(output logic timed_out);
        int cyc;
        cyc = 0;
        timed_out = 1'b0;
        while (!(tx_busy === 1'b1 && tx === 1'b0)) begin
            if (cyc >= 4000) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk_50MHz);
            cyc++;
        end
    endtask

    // Starts at the first negedge after START entry; samples each bit mid-period and
    // counts sample_ticks until tx_done_tick is seen.
    task automatic recv_frame(output logic [15:0] bits, output int nticks, output logic timed_out);
        int c;
        int cyc;
        bits = '0;
        c = 0;
        cyc = 0;
        timed_out = 1'b0;
        while (tx_done_tick !== 1'b1) begin
            if (cyc >= 4000) begin
                timed_out = 1'b1;
                break;
            end
            if (sample_tick) begin
                if (c % 16 == 8 && c / 16 < 16)
                    bits[c/16] = tx;
                c++;
            end
            @(negedge clk_50MHz);
            cyc++;
        end
        nticks = c;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic s2, input logic po);
        logic [15:0] bits;
        int          nt;
        logic        to;
        recv_frame(bits, nt, to);
        check({tag, "_done_timeout"}, to, 1'b0);
        check({tag, "_ticks"}, nt, 16 * exp_len(s2));
        check({tag, "_bits"}, bits, exp_frame(d, s2, po));
    endtask

    task automatic do_frame(input string tag, input logic [7:0] d, input logic s2, input logic po);
        logic to;
        wait_start(to);
        check({tag, "_start_timeout"}, to, 1'b0);
        check_frame(tag, d, s2, po);
    endtask

    logic [7:0] w [0:8];

    initial begin
        logic to;
        int   cyc;
        int   c;
        int   viol;

        w[0] = 8'h01; w[1] = 8'h80; w[2] = 8'h5A; w[3] = 8'hC3; w[4] = 8'h7E;
        w[5] = 8'h00; w[6] = 8'hFF; w[7] = 8'h96; w[8] = 8'h2B;

        // Reset values while reset is held.
        repeat (2) @(negedge clk_50MHz);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done_tick, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_empty", fifo_empty, 1'b1);
        check("rst_full", fifo_full, 1'b0);
        check("rst_count", fifo_count, 4'd0);
        reset = 1'b0;

        // 0xA5, one stop bit: line 0,1,0,1,0,0,1,0,1,1 (parity 0 inserted when enabled).
        stop2 = 1'b0;
        parity_odd = 1'b0;
        push(8'hA5);
        check("lat_count", fifo_count, 4'd1);
        check("lat_tx_idle", tx, 1'b1);
        check("lat_busy_idle", tx_busy, 1'b0);
        @(negedge clk_50MHz);
        check("lat_tx_start", tx, 1'b0);
        check("lat_busy_start", tx_busy, 1'b1);
        check("lat_empty", fifo_empty, 1'b1);
        check_frame("a5", 8'hA5, 1'b0, 1'b0);
        check("a5_busy_at_done", tx_busy, 1'b0);
        check("a5_tx_at_done", tx, 1'b1);
        @(negedge clk_50MHz);
        check("a5_done_pulse", tx_done_tick, 1'b0);
        check("a5_empty", fifo_empty, 1'b1);

        // Parity even then odd (parity bit 0, then 1 with the feature; ignored otherwise).
        parity_odd = 1'b0;
        push(8'hA5);
        do_frame("par_even", 8'hA5, 1'b0, 1'b0);
        parity_odd = 1'b1;
        push(8'hA5);
        do_frame("par_odd", 8'hA5, 1'b0, 1'b1);

        // Two stop bits; mid-frame changes to stop2/parity_odd must not matter.
        stop2 = 1'b1;
        parity_odd = 1'b0;
        push(8'h3C);
        wait_start(to);
        check("s2_start_timeout", to, 1'b0);
        stop2 = 1'b0;
        parity_odd = 1'b1;
        check_frame("s2", 8'h3C, 1'b1, 1'b0);
        stop2 = 1'b0;
        parity_odd = 1'b0;

        // Nine back-to-back pushes: first is popped, eight stored, then a dropped tenth.
        @(negedge clk_50MHz);
        data_in = w[0];
        wr_en = 1'b1;
        @(negedge clk_50MHz);
        data_in = w[1];
        @(negedge clk_50MHz);
        fork
            begin
                for (int i = 2; i < 9; i++) begin
                    data_in = w[i];
                    wr_en = 1'b1;
                    @(negedge clk_50MHz);
                end
                wr_en = 1'b0;
                check("burst_count", fifo_count, 4'd8);
                check("burst_full", fifo_full, 1'b1);
                check("burst_no_overflow", overflow, 1'b0);
                push(8'hEE);
                check("drop_overflow", overflow, 1'b1);
                check("drop_count", fifo_count, 4'd8);
            end
            begin
                check_frame("burst0", w[0], 1'b0, 1'b0);
            end
        join
        @(negedge clk_50MHz);
        check("gap_tx_start", tx, 1'b0);
        for (int i = 1; i < 9; i++)
            do_frame($sformatf("burst%0d", i), w[i], 1'b0, 1'b0);
        @(negedge clk_50MHz);
        check("burst_drained", fifo_empty, 1'b1);
        check("burst_overflow_sticky", overflow, 1'b1);

        // Push on the pop edge that follows a frame end with the FIFO full.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            data_in = w[i];
            wr_en = 1'b1;
            @(negedge clk_50MHz);
        end
        wr_en = 1'b0;
        check("edge_full_count", fifo_count, 4'd8);
        cyc = 0;
        while (tx_done_tick !== 1'b1 && cyc < 4000) begin
            @(negedge clk_50MHz);
            cyc++;
        end
        check("edge_done_timeout", (cyc >= 4000), 1'b0);
        push(8'h77);
        check("edge_count", fifo_count, 4'd8);
        check("edge_overflow", overflow, 1'b0);
        check("edge_full", fifo_full, 1'b1);

        // Reset roughly 70 ticks into a frame of zeros with three words queued.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            data_in = 8'h00;
            wr_en = 1'b1;
            @(negedge clk_50MHz);
        end
        wr_en = 1'b0;
        check("mid_queued", fifo_count, 4'd3);
        c = 0;
        while (c < 70) begin
            if (sample_tick)
                c++;
            @(negedge clk_50MHz);
        end
        check("mid_tx_low", tx, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_count", fifo_count, 4'd0);
        check("mid_rst_busy", tx_busy, 1'b0);
        check("mid_rst_empty", fifo_empty, 1'b1);
        repeat (2) @(negedge clk_50MHz);
        reset = 1'b0;
        viol = 0;
        repeat (1500) begin
            @(negedge clk_50MHz);
            if (tx !== 1'b1 || tx_busy !== 1'b0)
                viol++;
        end
        check("mid_no_more_frames", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised, buffered successor to the single-byte UART transmitter.
- Adds a write FIFO, runtime-selectable 1 or 2 stop bits, configurable oversampling and an optional parity bit.
- Sits between the command/data producer logic and the tx pin. Shares the baud generator's sample_tick with the UART receiver.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- OVERSAMPLE, 16, sample_tick pulses per bit period; legal range 4..64.
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..64.

Ports:
- clk_50MHz  in  1  system clock; all logic rises on this edge.
- reset  in  1  asynchronous, active-high.
- sample_tick  in  1  one-cycle pulse at OVERSAMPLE × baud rate.
- wr_en  in  1  push data_in into the FIFO this cycle.
- data_in  in  DATA_BITS  word to push.
- stop2  in  1  0 = 1 stop bit, 1 = 2 stop bits; sampled at frame start.
- parity_odd  in  1  0 = even parity, 1 = odd parity; sampled at frame start; used only with the feature enabled.
- tx  out  1  serial line; registered; idles high.
- tx_busy  out  1  high from START entry to the end of the last stop bit.
- tx_done_tick  out  1  one-cycle pulse when a frame completes.
- fifo_full  out  1  count == FIFO_DEPTH.
- fifo_empty  out  1  count == 0.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set by a dropped write; cleared only by reset.

Behaviour:
- Reset, asynchronous, takes effect immediately even mid-frame:
  - outputs: tx=1, tx_busy=0, tx_done_tick=0, overflow=0, fifo_empty=1, fifo_full=0, fifo_count=0;
  - internal: FIFO pointers 0, state IDLE, tick counter 0, bit counter 0.
  - FIFO contents are discarded.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - A write is accepted when wr_en=1 and either not full, or a pop occurs in the same cycle.
  - A write when full with no pop is dropped and sets overflow.
  - Simultaneous push and pop leaves count unchanged.
  - A write to an empty FIFO is not popped in the same cycle; there is no fall-through.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_busy=0.
  - If the FIFO is not empty: pop the head into the shift register, latch stop2 and parity_odd, clear the tick counter, go to START.
  - Latency: a write at edge N to an empty FIFO while IDLE gives tx=0 and tx_busy=1 after edge N+1.
- Bit timing:
  - Every bit lasts exactly OVERSAMPLE sample_ticks.
  - The tick counter advances only on sample_tick.
  - A state or bit transition occurs on the edge where the counter is at OVERSAMPLE-1 and sample_tick=1; the counter then returns to 0.
- START: tx=0 for one bit period, then go to DATA with the bit counter at 0.
- DATA:
  - tx = shift register bit 0.
  - At each bit end, shift right (fill with 1) and increment the bit counter.
  - After bit DATA_BITS-1, go to PARITY (feature enabled) or STOP.
- PARITY: tx = XOR of the latched data word, XOR latched parity_odd; lasts one bit period.
- STOP:
  - tx=1 for 1 or 2 bit periods, per the latched stop2.
  - At the final tick: tx_done_tick=1 for one cycle, go to IDLE.
  - If the FIFO is not empty, the next IDLE cycle starts a new frame: exactly one clk_50MHz idle cycle between frames.
- Mid-frame changes to stop2 or parity_odd have no effect on the current frame.
- A sample_tick arriving while in IDLE is ignored.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: the PARITY state is compiled in and one parity bit is inserted after the data bits, as described above.
- Undefined: no PARITY state; DATA goes directly to STOP. The parity_odd port is still present but ignored; frame length is 1+DATA_BITS+stop bits.

Test Plan:
- Reset, then push 0xA5, stop2=0, no parity → tx bit sequence 0,1,0,1,0,0,1,0,1,1; each bit 16 ticks; tx_done_tick after 160 ticks; fifo_empty back to 1.
- UART_TX_PARITY_EN defined, push 0xA5 with parity_odd=0, then with parity_odd=1 → parity bit 0, then 1; frame 176 ticks each.
- Push 0x3C with stop2=1 → tx high for 32 ticks after the data bits; frame 176 ticks (no parity).
- Push 9 words back-to-back with FIFO_DEPTH=8 while the first frame starts → first word popped; 8 stored; no overflow. A 10th push while full → overflow=1, word dropped; exactly 9 frames sent in order.
- Assert reset at tick 70 of a frame with 3 words queued → tx=1 immediately, fifo_count=0, tx_busy=0; no further frames are sent.
- Push exactly when full and a frame ends on the same edge → count stays 8; overflow stays 0.
